pipe_ctrl_hazard: RTL and testbench
===================================

// Module: pipe_ctrl_hazard
// PURPOSE
//  Consumer end of the decoder's control bundle in the 5-stage pipeline.
//  - Carries ID-stage control signals through the ID/EX, EX/MEM and MEM/WB registers.
//  - Resolves PCSrcE in EX.
//  - Detects load-use hazards and generates stall, flush and forwarding selects.
//  - Keeps saturating stall and flush event counters.
// PARAMETERS
//  RA_W   5   register-address width
//  ALUC_W 3   ALUControl width
//  CNT_W  16  event-counter width
// PORTS
//  clk          in  1       pipeline clock
//  reset_n      in  1       asynchronous, active-low reset
//  ResultSrcD   in  2       00 ALU, 01 load data, 10 PC+4
//  MemWriteD    in  1       ID store enable
//  BranchD      in  1       ID conditional branch (decoder exports Branch, not PCSrc)
//  JumpD        in  1       ID jump
//  ALUSrcD      in  1       ID ALU B-operand select
//  RegWriteD    in  1       ID writeback enable
//  ALUControlD  in  ALUC_W  ID ALU operation
//  Rs1D,Rs2D,RdD in RA_W    ID register addresses
//  ZeroE        in  1       ALU zero flag from EX
//  ALUControlE  out ALUC_W  EX ALU operation
//  ALUSrcE      out 1       EX ALU B-operand select
//  PCSrcE       out 1       (BranchE & ZeroE) | JumpE, combinational
//  MemWriteM    out 1       MEM store enable
//  RegWriteW    out 1       WB writeback enable
//  ResultSrcW   out 2       WB result select
//  RdW          out RA_W    WB destination register
//  StallF,StallD out 1      hold PC and IF/ID
//  FlushD,FlushE out 1      bubble IF/ID and ID/EX
//  ForwardAE,ForwardBE out 2  00 register file, 01 WB result, 10 MEM ALU result
//  stall_cnt,flush_cnt out CNT_W  event counters
// BEHAVIOUR
//  - Reset (async, reset_n=0): every stage register, and therefore every registered output,
//    clears to 0; counters clear to 0. No pipeline register holds an X after reset.
//  - Load-use hazard:
//    lwStall = ResultSrcE==01 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE)
//  - Stall and flush outputs (all combinational, same cycle):
//    - StallF = StallD = lwStall
//    - FlushD = PCSrcE
//    - FlushE = lwStall | PCSrcE
//  - ID/EX register:
//    - FlushE=1: clears all control fields (RegWrite, MemWrite, Branch, Jump, ResultSrc)
//      to 0 and RdE, Rs1E, Rs2E to 0.
//    - Otherwise loads the D inputs.
//  - EX/MEM and MEM/WB never stall or flush; they advance every cycle.
//  - Forwarding, operand A; operand B is the same with Rs2E:
//    - 10 if RegWriteM & RdM!=0 & RdM==Rs1E
//    - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E
//    - else 00
//    - MEM takes priority over WB.
//    - x0 is never forwarded.
//  - Latency:
//    - ID controls appear at EX outputs 1 cycle later, at MEM 2 cycles later, at WB 3.
//    - PCSrcE and Forward* are combinational from EX/MEM/WB state.
//  - Simultaneous lwStall & PCSrcE:
//    - StallF, StallD, FlushD and FlushE all assert.
//    - The IF/ID register gives FlushD priority over StallD, so the wrong-path instruction dies.
//    - stall_cnt does not increment; flush_cnt does.
//  - Counters, each saturating at 2^CNT_W-1:
//    - stall_cnt increments on cycles with lwStall & !PCSrcE.
//    - flush_cnt increments on cycles with PCSrcE.
//  - Reset mid-stall: the bubble is discarded, the pipeline restarts empty, all selects read 00.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - RESULT_ALU / RESULT_MEM / RESULT_PC4 encodings
//    - FWD_RF / FWD_WB / FWD_MEM encodings
//    - RA_W default
//    - packed ctrl_ex_t, ctrl_mem_t, ctrl_wb_t field groupings
//  - One sub-module, hazard_fwd_unit: purely combinational lwStall, stall/flush and forward logic.
//    Stage registers and counters stay in the top module.
// TESTING
//  1. Reset: hold reset_n=0 with random D inputs, release.
//     -> all outputs 0 for the first cycle; RegWriteW=0 until a valid instruction reaches WB.
//  2. Back-to-back ALU dependency: add x5 then sub uses x5.
//     -> ForwardAE=10 in the sub's EX cycle.
//     -> With one nop between them, ForwardAE=01.
//  3. Load-use: lw x6 then add uses x6.
//     -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardBE=01, stall_cnt=1.
//  4. beq taken (BranchD=1, ZeroE=1).
//     -> PCSrcE=1, FlushD=FlushE=1 for one cycle, flush_cnt=1.
//     -> The flushed instruction never asserts MemWriteM or RegWriteW.
//  5. Load-use coincident with a taken jump.
//     -> Both flushes assert, flush_cnt+1, stall_cnt unchanged.
//  6. Writes to x0 from both MEM and WB matching Rs1E=0.
//     -> ForwardAE=00. Also force stall_cnt to 0xFFFF then a stall -> stays 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and stage-register field groupings for the pipeline control path.
package pipe_pkg;

  localparam int RA_W_DEF   = 5;
  localparam int ALUC_W_DEF = 3;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic alu_src;
    logic branch;
    logic jump;
  } ctrl_ex_t;

  typedef struct packed {
    logic mem_write;
  } ctrl_mem_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
  } ctrl_wb_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection, stall/flush generation and EX operand forwarding selects.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  result_src_t     result_src_e,
  input  logic            pc_src_e,
  input  logic            reg_write_m,
  input  logic [RA_W-1:0] rd_m,
  input  logic            reg_write_w,
  input  logic [RA_W-1:0] rd_w,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output fwd_sel_t        forward_ae,
  output fwd_sel_t        forward_be
);

  logic lw_stall;

  assign lw_stall = (result_src_e == RESULT_MEM) && (rd_e != '0) &&
                    ((rs1_d == rd_e) || (rs2_d == rd_e));

  assign stall_f = lw_stall;
  assign stall_d = lw_stall;
  assign flush_d = pc_src_e;
  assign flush_e = lw_stall | pc_src_e;

  // MEM holds the younger result, so it wins over WB; x0 is hardwired and never forwarded.
  always_comb begin
    // NOTE: every output gets a default before the ifs so no path leaves it unassigned (no latch).
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      forward_ae = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) forward_ae = FWD_WB;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      forward_be = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) forward_be = FWD_WB;
  end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB, resolves PCSrcE and
// counts stall and flush events; hazard and forwarding decisions live in hazard_fwd_unit.
module pipe_ctrl_hazard
  import pipe_pkg::*;
#(
  parameter int RA_W   = RA_W_DEF,
  parameter int ALUC_W = ALUC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              ALUSrcD,
  input  logic              RegWriteD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [RA_W-1:0]   Rs1D,
  input  logic [RA_W-1:0]   Rs2D,
  input  logic [RA_W-1:0]   RdD,
  input  logic              ZeroE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcE,
  output logic              PCSrcE,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [RA_W-1:0]   RdW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_wb_t          wb_e_q, wb_e_d, wb_m_q, wb_m_d, wb_w_q, wb_w_d;
  ctrl_mem_t         mem_e_q, mem_e_d, mem_m_q, mem_m_d;
  ctrl_ex_t          ex_e_q, ex_e_d;
  logic [ALUC_W-1:0] alu_control_e_q, alu_control_e_d;
  logic [RA_W-1:0]   rd_e_q, rd_e_d, rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  logic [RA_W-1:0]   rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              pc_src_e, stall_f, stall_d, flush_d, flush_e;
  fwd_sel_t          fwd_a, fwd_b;

  assign pc_src_e = (ex_e_q.branch & ZeroE) | ex_e_q.jump;

  hazard_fwd_unit #(.RA_W(RA_W)) u_hazard (
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .rs1_e        (rs1_e_q),
    .rs2_e        (rs2_e_q),
    .rd_e         (rd_e_q),
    .result_src_e (wb_e_q.result_src),
    .pc_src_e     (pc_src_e),
    .reg_write_m  (wb_m_q.reg_write),
    .rd_m         (rd_m_q),
    .reg_write_w  (wb_w_q.reg_write),
    .rd_w         (rd_w_q),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .forward_ae   (fwd_a),
    .forward_be   (fwd_b)
  );

  always_comb begin
    // A flushed ID/EX slot becomes an all-zero bubble: it writes nothing and branches nowhere.
    wb_e_d          = '0;
    mem_e_d         = '0;
    ex_e_d          = '0;
    alu_control_e_d = '0;
    rd_e_d          = '0;
    rs1_e_d         = '0;
    rs2_e_d         = '0;
    if (!flush_e) begin
      wb_e_d.reg_write  = RegWriteD;
      wb_e_d.result_src = result_src_t'(ResultSrcD);
      mem_e_d.mem_write = MemWriteD;
      ex_e_d.alu_src    = ALUSrcD;
      ex_e_d.branch     = BranchD;
      ex_e_d.jump       = JumpD;
      alu_control_e_d   = ALUControlD;
      rd_e_d            = RdD;
      rs1_e_d           = Rs1D;
      rs2_e_d           = Rs2D;
    end

    wb_m_d  = wb_e_q;
    mem_m_d = mem_e_q;
    rd_m_d  = rd_e_q;
    wb_w_d  = wb_m_q;
    rd_w_d  = rd_m_q;

    // A coincident branch/jump kills the stalled instruction, so that cycle counts only as a flush.
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && !pc_src_e && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_src_e && (flush_cnt_q != '1))             flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every stage register is reset, not just the valid bits, so no X ever reaches the forwarding compares.
      wb_e_q          <= '0;
      mem_e_q         <= '0;
      ex_e_q          <= '0;
      alu_control_e_q <= '0;
      rd_e_q          <= '0;
      rs1_e_q         <= '0;
      rs2_e_q         <= '0;
      wb_m_q          <= '0;
      mem_m_q         <= '0;
      rd_m_q          <= '0;
      wb_w_q          <= '0;
      rd_w_q          <= '0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage read its predecessor's pre-edge value.
      wb_e_q          <= wb_e_d;
      mem_e_q         <= mem_e_d;
      ex_e_q          <= ex_e_d;
      alu_control_e_q <= alu_control_e_d;
      rd_e_q          <= rd_e_d;
      rs1_e_q         <= rs1_e_d;
      rs2_e_q         <= rs2_e_d;
      wb_m_q          <= wb_m_d;
      mem_m_q         <= mem_m_d;
      rd_m_q          <= rd_m_d;
      wb_w_q          <= wb_w_d;
      rd_w_q          <= rd_w_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign ALUControlE = alu_control_e_q;
  assign ALUSrcE     = ex_e_q.alu_src;
  assign PCSrcE      = pc_src_e;
  assign MemWriteM   = mem_m_q.mem_write;
  assign RegWriteW   = wb_w_q.reg_write;
  assign ResultSrcW  = wb_w_q.result_src;
  assign RdW         = rd_w_q;
  assign StallF      = stall_f;
  assign StallD      = stall_d;
  assign FlushD      = flush_d;
  assign FlushE      = flush_e;
  assign ForwardAE   = fwd_a;
  assign ForwardBE   = fwd_b;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: directed scenarios plus random traffic against a queue-based
// model where pipe[0..2] hold the instructions occupying EX, MEM and WB.
module tb_pipe_ctrl_hazard;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic [2:0]  alu_control;
    logic        alu_src;
    logic        pc_src;
    logic        mem_write_m;
    logic        reg_write_w;
    logic [1:0]  result_src_w;
    logic [4:0]  rd_w;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ResultSrcD = '0;
  logic        MemWriteD = 1'b0, BranchD = 1'b0, JumpD = 1'b0, ALUSrcD = 1'b0, RegWriteD = 1'b0;
  logic [2:0]  ALUControlD = '0;
  logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0;
  logic        ZeroE = 1'b0;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, PCSrcE, MemWriteM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stall_cnt, flush_cnt;

  int     n_vec = 0;
  int     n_err = 0;
  instr_t pipe[$];
  int     m_stall, m_flush;
  outs_t  cur_exp, cur_act;
  instr_t nop = '0;

  pipe_ctrl_hazard #(.RA_W(5), .ALUC_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic instr_t rand_instr();
    instr_t r;
    r.result_src  = 2'($urandom_range(0, 2));
    r.mem_write   = 1'($urandom_range(0, 1));
    r.branch      = ($urandom_range(0, 3) == 0);
    r.jump        = ($urandom_range(0, 7) == 0);
    r.alu_src     = 1'($urandom_range(0, 1));
    r.reg_write   = 1'($urandom_range(0, 1));
    r.alu_control = 3'($urandom_range(0, 7));
    r.rs1         = 5'($urandom_range(0, 7));
    r.rs2         = 5'($urandom_range(0, 7));
    r.rd          = 5'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic logic [1:0] model_fwd(input instr_t mem, input instr_t wb, input logic [4:0] rs);
    if (mem.reg_write && mem.rd != 0 && mem.rd == rs) return 2'b10;
    if (wb.reg_write && wb.rd != 0 && wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outs_t model_outs(input instr_t d, input logic z);
    outs_t  o;
    instr_t ex, mem, wb;
    logic   lw, pcs;
    ex  = pipe[0];
    mem = pipe[1];
    wb  = pipe[2];
    pcs = (ex.branch && z) || ex.jump;
    lw  = (ex.result_src == 2'b01) && (ex.rd != 0) && (d.rs1 == ex.rd || d.rs2 == ex.rd);
    o.alu_control  = ex.alu_control;
    o.alu_src      = ex.alu_src;
    o.pc_src       = pcs;
    o.mem_write_m  = mem.mem_write;
    o.reg_write_w  = wb.reg_write;
    o.result_src_w = wb.result_src;
    o.rd_w         = wb.rd;
    o.stall_f      = lw;
    o.stall_d      = lw;
    o.flush_d      = pcs;
    o.flush_e      = lw || pcs;
    o.fwd_a        = model_fwd(mem, wb, ex.rs1);
    o.fwd_b        = model_fwd(mem, wb, ex.rs2);
    o.stall_cnt    = 16'(m_stall);
    o.flush_cnt    = 16'(m_flush);
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.alu_control  = ALUControlE;
    o.alu_src      = ALUSrcE;
    o.pc_src       = PCSrcE;
    o.mem_write_m  = MemWriteM;
    o.reg_write_w  = RegWriteW;
    o.result_src_w = ResultSrcW;
    o.rd_w         = RdW;
    o.stall_f      = StallF;
    o.stall_d      = StallD;
    o.flush_d      = FlushD;
    o.flush_e      = FlushE;
    o.fwd_a        = ForwardAE;
    o.fwd_b        = ForwardBE;
    o.stall_cnt    = stall_cnt;
    o.flush_cnt    = flush_cnt;
    return o;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(nop);
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic drive(input instr_t d, input logic z);
    ResultSrcD  = d.result_src;
    MemWriteD   = d.mem_write;
    BranchD     = d.branch;
    JumpD       = d.jump;
    ALUSrcD     = d.alu_src;
    RegWriteD   = d.reg_write;
    ALUControlD = d.alu_control;
    Rs1D        = d.rs1;
    Rs2D        = d.rs2;
    RdD         = d.rd;
    ZeroE       = z;
  endtask

  // Drive one ID instruction, sample everything, then advance the model past the next edge.
  task automatic cycle(input instr_t d, input logic z);
    drive(d, z);
    #1;
    cur_exp = model_outs(d, z);
    cur_act = dut_outs();
    if (cur_exp.stall_f && !cur_exp.pc_src && m_stall < 65535) m_stall++;
    if (cur_exp.pc_src && m_flush < 65535) m_flush++;
    pipe.push_front(cur_exp.flush_e ? nop : d);
    void'(pipe.pop_back());
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drive(nop, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(), 1'($urandom_range(0, 1)));
      #1;
      cur_act = dut_outs();
      n_vec++;
      if (cur_act !== '0) begin
        n_err++;
        $display("FAIL reset_hold: outputs %h, expected all zero", cur_act);
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(rand_instr(), 1'($urandom_range(0, 1)));
      if (i == 0) begin
        n_vec++;
        if (cur_act !== '0) begin
          n_err++;
          $display("FAIL reset_first_cycle: outputs %h, expected all zero", cur_act);
        end
      end
      if (i < 3) begin
        n_vec++;
        if (cur_act.reg_write_w !== 1'b0) begin
          n_err++;
          $display("FAIL reset_regwrite_w: cycle %0d RegWriteW=%b, expected 0", i, cur_act.reg_write_w);
        end
      end
      n_vec++;
      if (cur_act !== cur_exp) begin
        n_err++;
        $display("FAIL reset_model: cycle %0d got %h expected %h", i, cur_act, cur_exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_t add_i, sub_i;
    apply_reset();
    add_i = '0; add_i.reg_write = 1'b1; add_i.rd = 5; add_i.rs1 = 1; add_i.rs2 = 2;
    sub_i = '0; sub_i.reg_write = 1'b1; sub_i.rd = 7; sub_i.rs1 = 5; sub_i.rs2 = 3;
    sub_i.alu_control = 3'b001;
    cycle(add_i, 1'b0);
    cycle(sub_i, 1'b0);
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.fwd_a !== 2'b10 || cur_act !== cur_exp) begin
      n_err++;
      $display("FAIL b2b_fwd_mem: ForwardAE=%b outs %h, expected 10 outs %h", cur_act.fwd_a, cur_act, cur_exp);
    end
    cycle(add_i, 1'b0);
    cycle(nop, 1'b0);
    cycle(sub_i, 1'b0);
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.fwd_a !== 2'b01 || cur_act !== cur_exp) begin
      n_err++;
      $display("FAIL b2b_fwd_wb: ForwardAE=%b outs %h, expected 01 outs %h", cur_act.fwd_a, cur_act, cur_exp);
    end
  endtask

  task automatic test_load_use();
    instr_t lw_i, add_i;
    apply_reset();
    lw_i  = '0; lw_i.result_src = 2'b01; lw_i.reg_write = 1'b1; lw_i.rd = 6; lw_i.rs1 = 1;
    add_i = '0; add_i.reg_write = 1'b1; add_i.rd = 8; add_i.rs1 = 2; add_i.rs2 = 6;
    cycle(lw_i, 1'b0);
    cycle(add_i, 1'b0);
    n_vec++;
    if ({cur_act.stall_f, cur_act.stall_d, cur_act.flush_d, cur_act.flush_e} !== 4'b1101) begin
      n_err++;
      $display("FAIL lu_stall: StallF/StallD/FlushD/FlushE=%b%b%b%b, expected 1101",
               cur_act.stall_f, cur_act.stall_d, cur_act.flush_d, cur_act.flush_e);
    end
    cycle(add_i, 1'b0);
    n_vec++;
    if ({cur_act.stall_f, cur_act.flush_e} !== 2'b00 || cur_act.stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL lu_release: StallF=%b FlushE=%b stall_cnt=%0d, expected 0 0 1",
               cur_act.stall_f, cur_act.flush_e, cur_act.stall_cnt);
    end
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.fwd_b !== 2'b01 || cur_act !== cur_exp) begin
      n_err++;
      $display("FAIL lu_fwd_b: ForwardBE=%b outs %h, expected 01 outs %h", cur_act.fwd_b, cur_act, cur_exp);
    end
  endtask

  task automatic test_branch_taken();
    instr_t beq_i, wrong_i;
    apply_reset();
    beq_i   = '0; beq_i.branch = 1'b1; beq_i.rs1 = 1; beq_i.rs2 = 2;
    wrong_i = '0; wrong_i.mem_write = 1'b1; wrong_i.reg_write = 1'b1; wrong_i.rd = 9; wrong_i.rs1 = 3;
    cycle(beq_i, 1'b0);
    cycle(wrong_i, 1'b1);
    n_vec++;
    if ({cur_act.pc_src, cur_act.flush_d, cur_act.flush_e} !== 3'b111 || cur_act.flush_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL br_flush: PCSrcE/FlushD/FlushE=%b%b%b flush_cnt=%0d, expected 111 0",
               cur_act.pc_src, cur_act.flush_d, cur_act.flush_e, cur_act.flush_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(nop, 1'b0);
      n_vec++;
      if (cur_act.mem_write_m !== 1'b0 || cur_act.reg_write_w !== 1'b0 ||
          cur_act.flush_cnt !== 16'd1 || cur_act.pc_src !== 1'b0) begin
        n_err++;
        $display("FAIL br_killed: cycle %0d MemWriteM=%b RegWriteW=%b flush_cnt=%0d PCSrcE=%b, expected 0 0 1 0",
                 i, cur_act.mem_write_m, cur_act.reg_write_w, cur_act.flush_cnt, cur_act.pc_src);
      end
    end
  endtask

  task automatic test_load_use_jump();
    instr_t ljmp_i, use_i;
    apply_reset();
    ljmp_i = '0; ljmp_i.jump = 1'b1; ljmp_i.result_src = 2'b01; ljmp_i.reg_write = 1'b1; ljmp_i.rd = 6;
    use_i  = '0; use_i.reg_write = 1'b1; use_i.rd = 10; use_i.rs1 = 6;
    cycle(ljmp_i, 1'b0);
    cycle(use_i, 1'b0);
    n_vec++;
    if ({cur_act.stall_f, cur_act.stall_d, cur_act.flush_d, cur_act.flush_e} !== 4'b1111) begin
      n_err++;
      $display("FAIL lj_all: StallF/StallD/FlushD/FlushE=%b%b%b%b, expected 1111",
               cur_act.stall_f, cur_act.stall_d, cur_act.flush_d, cur_act.flush_e);
    end
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.flush_cnt !== 16'd1 || cur_act.stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL lj_counts: flush_cnt=%0d stall_cnt=%0d, expected 1 0", cur_act.flush_cnt, cur_act.stall_cnt);
    end
  endtask

  task automatic test_x0_and_saturation();
    instr_t w0a, w0b, use_i, lw_i, add_i;
    apply_reset();
    w0a   = '0; w0a.reg_write = 1'b1; w0a.rs1 = 4;
    w0b   = '0; w0b.reg_write = 1'b1; w0b.rs1 = 5;
    use_i = '0; use_i.reg_write = 1'b1; use_i.rd = 11;
    cycle(w0a, 1'b0);
    cycle(w0b, 1'b0);
    cycle(use_i, 1'b0);
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.fwd_a !== 2'b00 || cur_act.fwd_b !== 2'b00) begin
      n_err++;
      $display("FAIL x0_fwd: ForwardAE=%b ForwardBE=%b, expected 00 00", cur_act.fwd_a, cur_act.fwd_b);
    end
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    m_stall = 65535;
    lw_i  = '0; lw_i.result_src = 2'b01; lw_i.reg_write = 1'b1; lw_i.rd = 6;
    add_i = '0; add_i.rs1 = 6; add_i.rd = 12; add_i.reg_write = 1'b1;
    cycle(lw_i, 1'b0);
    cycle(add_i, 1'b0);
    cycle(nop, 1'b0);
    n_vec++;
    if (cur_act.stall_cnt !== 16'hFFFF || cur_act !== cur_exp) begin
      n_err++;
      $display("FAIL stall_sat: stall_cnt=%h outs %h, expected FFFF outs %h", cur_act.stall_cnt, cur_act, cur_exp);
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t lw_i, add_i;
    apply_reset();
    lw_i  = '0; lw_i.result_src = 2'b01; lw_i.reg_write = 1'b1; lw_i.rd = 7;
    add_i = '0; add_i.rs2 = 7; add_i.rd = 13; add_i.reg_write = 1'b1;
    cycle(lw_i, 1'b0);
    drive(add_i, 1'b0);
    #1;
    n_vec++;
    if (StallF !== 1'b1) begin
      n_err++;
      $display("FAIL mid_stall_pre: StallF=%b, expected 1", StallF);
    end
    reset_n = 1'b0;
    #1;
    cur_act = dut_outs();
    n_vec++;
    if (cur_act !== '0) begin
      n_err++;
      $display("FAIL mid_stall_reset: outputs %h, expected all zero", cur_act);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(add_i, 1'b0);
    n_vec++;
    if (cur_act.stall_f !== 1'b0 || cur_act !== cur_exp) begin
      n_err++;
      $display("FAIL mid_stall_restart: outs %h, expected %h", cur_act, cur_exp);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(rand_instr(), 1'($urandom_range(0, 1)));
      n_vec++;
      if (cur_act !== cur_exp) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got %h expected %h", i, cur_act, cur_exp);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch_taken();
    test_load_use_jump();
    test_x0_and_saturation();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
